// File: rtl/sram_1rw1r_param.sv
// One read/write plus one read-only port SRAM with a byte-masked write and registered reads.
// Define SRAM_INIT_CLEAR_EN to zero the whole array after reset before the ports open.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk0,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dout0_valid,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    dout1_valid,
  output logic                    collision
);

  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  v0_q, v1_q;
  logic                  coll_q;

  logic rd0, wr0, rd1, coll;

  assign ready = (state_q == RUN);
  assign rd0   = ready && !csb0 && web0;
  assign wr0   = ready && !csb0 && !web0;
  assign rd1   = ready && !csb1;
  assign coll  = wr0 && rd1 && (addr0 == addr1);

`ifdef SRAM_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr;

  assign clr = rst_n && (state_q == INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // Array carries no reset; only the clear walk and port 0 write it.
  always_ff @(posedge clk0) begin
`ifdef SRAM_INIT_CLEAR_EN
    if (clr) begin
      mem_q[cnt_q] <= '0;
    end
`endif
    if (wr0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    dout0_d = dout0_q;
    if (rd0) begin
      dout0_d = mem_q[addr0];
    end
  end

  // Colliding read sees new bytes on masked lanes, old bytes elsewhere.
  always_comb begin
    dout1_d = dout1_q;
    if (rd1) begin
      dout1_d = mem_q[addr1];
      if (coll) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          if (wmask0[i]) begin
            dout1_d[8*i +: 8] = din0[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      dout0_q <= '0;
      dout1_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      v0_q    <= rd0;
      v1_q    <= rd1;
      coll_q  <= coll;
    end
  end

  assign dout0       = dout0_q;
  assign dout1       = dout1_q;
  assign dout0_valid = v0_q;
  assign dout1_valid = v1_q;
  assign collision   = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench for sram_1rw1r_param at default parameters.
// Init-length and zero-read checks follow SRAM_INIT_CLEAR_EN.
module tb_sram_1rw1r_param;

`ifdef SRAM_INIT_CLEAR_EN
  localparam int EXP_EDGES = 256;
`else
  localparam int EXP_EDGES = 1;
`endif

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic        dout0_valid, dout1_valid, collision;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_param dut (
    .clk0        (clk0),
    .rst_n       (rst_n),
    .ready       (ready),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .collision   (collision)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    csb1   = 1'b1;
    wmask0 = 4'h0;
    addr0  = 8'h00;
    addr1  = 8'h00;
    din0   = 32'h0;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d,
                    input logic [3:0] m);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
    tick();
    idle();
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = a;
    tick();
    idle();
  endtask

  task automatic rd1(input logic [7:0] a);
    csb1  = 1'b0;
    addr1 = a;
    tick();
    idle();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, n, EXP_EDGES);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    chk("rst_v0", {31'b0, dout0_valid}, 32'h0);
    chk("rst_v1", {31'b0, dout1_valid}, 32'h0);
    chk("rst_coll", {31'b0, collision}, 32'h0);

    rst_n = 1'b1;
    wait_ready("init_edges");

`ifdef SRAM_INIT_CLEAR_EN
    rd0(8'h00);
    chk("clr_rd0_00", dout0, 32'h0);
    rd1(8'hFF);
    chk("clr_rd1_ff", dout1, 32'h0);
`endif

    wr(8'h10, 32'hDEADBEEF, 4'b1111);
    chk("wr_v0", {31'b0, dout0_valid}, 32'h0);
    chk("wr_dout0", dout0, 32'h0);
    rd0(8'h10);
    chk("rd0_data", dout0, 32'hDEADBEEF);
    chk("rd0_v", {31'b0, dout0_valid}, 32'h1);
    tick();
    chk("rd0_v_drop", {31'b0, dout0_valid}, 32'h0);
    chk("rd0_hold", dout0, 32'hDEADBEEF);

    wr(8'h10, 32'h11223344, 4'b0101);
    rd1(8'h10);
    chk("mask_rd1", dout1, 32'hDE22BE44);
    chk("mask_v1", {31'b0, dout1_valid}, 32'h1);

    wr(8'h20, 32'h55555555, 4'b1111);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = 8'h20;
    din0   = 32'hAAAAAAAA;
    wmask0 = 4'b0011;
    csb1   = 1'b0;
    addr1  = 8'h20;
    tick();
    idle();
    chk("coll_dout1", dout1, 32'h5555AAAA);
    chk("coll_flag", {31'b0, collision}, 32'h1);
    chk("coll_v1", {31'b0, dout1_valid}, 32'h1);
    tick();
    chk("coll_drop", {31'b0, collision}, 32'h0);
    rd0(8'h20);
    chk("coll_store", dout0, 32'h5555AAAA);

    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = 8'h10;
    csb1  = 1'b0;
    addr1 = 8'h10;
    tick();
    idle();
    chk("dual_d0", dout0, 32'hDE22BE44);
    chk("dual_d1", dout1, 32'hDE22BE44);
    chk("dual_coll", {31'b0, collision}, 32'h0);

    wr(8'h10, 32'hFFFFFFFF, 4'b0000);
    rd0(8'h10);
    chk("nomask", dout0, 32'hDE22BE44);

    wr(8'hFF, 32'h12345678, 4'b1111);
    wr(8'h7F, 32'h0BADF00D, 4'b1111);
    rd0(8'hFF);
    chk("top_ff", dout0, 32'h12345678);
    rd1(8'h7F);
    chk("top_7f", dout1, 32'h0BADF00D);

    rst_n = 1'b0;
    #1;
    chk("arst_dout0", dout0, 32'h0);
    chk("arst_dout1", dout1, 32'h0);
    chk("arst_ready", {31'b0, ready}, 32'h0);
    tick();
    rst_n = 1'b1;
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = 8'hFF;
    tick();
    idle();
    chk("ign_v0", {31'b0, dout0_valid}, 32'h0);
    chk("ign_dout0", dout0, 32'h0);
    for (int i = 1; i < 100; i++) tick();
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = 8'hFF;
    csb1  = 1'b0;
    addr1 = 8'h7F;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_ready", {31'b0, ready}, 32'h0);
    chk("mid_v0", {31'b0, dout0_valid}, 32'h0);
    chk("mid_v1", {31'b0, dout1_valid}, 32'h0);
    chk("mid_dout0", dout0, 32'h0);
    chk("mid_dout1", dout1, 32'h0);
    chk("mid_coll", {31'b0, collision}, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_ready("reinit_edges");
`ifdef SRAM_INIT_CLEAR_EN
    rd0(8'hFF);
    chk("reclr_ff", dout0, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address width; RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL derive localparam NUM_WMASKS = DATA_WIDTH/8: one write-mask bit per byte lane.
REQ-004 SHALL have port clk0  in  1  the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ready  out  1  high when the ports accept requests.
REQ-007 SHALL have port csb0  in  1  port 0 active-low chip select.
REQ-008 SHALL have port web0  in  1  port 0 active-low write enable.
REQ-009 SHALL have port wmask0  in  NUM_WMASKS  port 0 byte write mask; bit i enables din0[8i+7:8i].
REQ-010 SHALL have port addr0  in  ADDR_WIDTH  port 0 address.
REQ-011 SHALL have port din0  in  DATA_WIDTH  port 0 write data.
REQ-012 SHALL have port dout0  out  DATA_WIDTH  port 0 read data.
REQ-013 SHALL have port dout0_valid  out  1  dout0 updated this cycle.
REQ-014 SHALL have port csb1  in  1  port 1 (read-only) active-low chip select.
REQ-015 SHALL have port addr1  in  ADDR_WIDTH  port 1 address.
REQ-016 SHALL have port dout1  out  DATA_WIDTH  port 1 read data.
REQ-017 SHALL have port dout1_valid  out  1  dout1 updated this cycle.
REQ-018 SHALL have port collision  out  1  one-cycle pulse: same-edge port 0 write and port 1 read of the same address.

Function
REQ-019 SHALL accept a port request only on an edge where ready=1; otherwise the request is ignored and the port's valid output is 0 next cycle.
REQ-020 SHALL perform a port 0 write (csb0=0, web0=0) on the sampling edge, updating only the byte lanes with wmask0 bit set; wmask0=0 leaves memory unchanged.
REQ-021 SHALL return a read (port 0 csb0=0, web0=1; port 1 csb1=0) with latency 1: dout and valid are registered on the sampling edge and valid is high for exactly one cycle per accepted read.
REQ-022 SHALL hold dout0/dout1 at their last value when no read is accepted (never X); a port 0 write leaves dout0 unchanged and dout0_valid=0.
REQ-023 SHALL, on a collision, return to dout1 the newly written bytes for masked lanes and the old bytes for unmasked lanes, and assert collision for one cycle.
REQ-024 SHALL allow both ports to read the same address on the same edge, both returning the stored word, with no collision.
REQ-025 SHALL implement a two-state FSM: INIT (ready=0) and RUN (ready=1); INIT moves to RUN as defined in REQ-030/031; RUN is left only by reset.
REQ-026 SHALL increment address counters with no wrap beyond RAM_DEPTH-1 during INIT; port addresses use the full ADDR_WIDTH range with no aliasing.

Reset
REQ-027 SHALL, while rst_n=0, force dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision=0, ready=0, FSM=INIT, init counter=0.
REQ-028 SHALL not alter memory contents by reset itself; contents are defined only by REQ-030/031.
REQ-029 SHALL, if reset is asserted mid-read or mid-clear, discard the in-flight result and restart from INIT after rst_n rises.

Configuration
REQ-030 SHALL, with SRAM_INIT_CLEAR_EN defined, in INIT write 0 to address 0..RAM_DEPTH-1, one address per cycle, and enter RUN on the edge after address RAM_DEPTH-1 is written (ready high RAM_DEPTH cycles after the first edge with rst_n=1).
REQ-031 SHALL, without SRAM_INIT_CLEAR_EN, enter RUN on the first rising edge with rst_n=1, with memory contents undefined until written.

Verification
REQ-032 SHALL check, with the macro defined and defaults: release reset -> ready rises after 256 edges; a read of any address then returns 0x00000000.
REQ-033 SHALL check: write addr0=0x10 din0=0xDEADBEEF wmask0=4'b1111, then port 0 read 0x10 -> dout0=0xDEADBEEF, dout0_valid high 1 cycle.
REQ-034 SHALL check: with 0x10 holding 0xDEADBEEF, write din0=0x11223344 wmask0=4'b0101 -> port 1 read gives 0xDE22BE44.
REQ-035 SHALL check a collision: same edge port 0 write 0x20 din0=0xAAAAAAAA mask 4'b0011 over 0x55555555 and port 1 read 0x20 -> dout1=0x5555AAAA, collision=1 for one cycle.
REQ-036 SHALL check: rst_n pulsed low mid-clear at cycle 100 -> all outputs 0 at once; the clear restarts, and ready rises 256 edges after release.
